// File: rtl/hbridge_coil_array_pkg.sv
// Shared types and helpers for the H-bridge coil array model.
package hbridge_coil_pkg;

    typedef enum logic [2:0] {
        MODE_FWD,
        MODE_REV,
        MODE_SLOW,
        MODE_COAST,
        MODE_SHOOT
    } bridge_mode_t;

    // Largest current magnitude representable; the most negative code is never used
    function automatic int cur_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    // Gate pattern to bridge mode, shoot-through first, forward/reverse swapped by inv
    function automatic bridge_mode_t decode_mode(input logic h1, input logic l1,
                                                 input logic h2, input logic l2,
                                                 input logic inv);
        bridge_mode_t m;
        if ((h1 && l1) || (h2 && l2))
            m = MODE_SHOOT;
        else if (h1 && l2)
            m = inv ? MODE_REV : MODE_FWD;
        else if (h2 && l1)
            m = inv ? MODE_FWD : MODE_REV;
        else if ((l1 && l2) || (h1 && h2))
            m = MODE_SLOW;
        else
            m = MODE_COAST;
        return m;
    endfunction

endpackage

// File: rtl/hbridge_coil_array_if.sv
// Bridge gates, sense and fault signals for all coils of the array.
interface hbridge_coil_array_if #(
    parameter int CHANNELS = 2,
    parameter int CUR_W    = 13,
    parameter int DUTY_W   = 12
);
    logic [CHANNELS-1:0]        high_1;
    logic [CHANNELS-1:0]        low_1;
    logic [CHANNELS-1:0]        high_2;
    logic [CHANNELS-1:0]        low_2;
    logic [CHANNELS-1:0]        polarity_invert;
    logic [CHANNELS-1:0]        analog_out;
    logic [CHANNELS-1:0]        analog_cmp;
    logic [CHANNELS*CUR_W-1:0]  current;
    logic [CHANNELS*DUTY_W-1:0] target;
    logic [CHANNELS-1:0]        shoot_through;

    modport master (
        output high_1, low_1, high_2, low_2, polarity_invert, analog_out,
        input  analog_cmp, current, target, shoot_through
    );

    modport slave (
        input  high_1, low_1, high_2, low_2, polarity_invert, analog_out,
        output analog_cmp, current, target, shoot_through
    );
endinterface

// File: rtl/hbridge_coil_array_channel.sv
// One coil: gate decode, saturating current integrator, duty accumulator
// and delayed hysteretic comparator.
module hbridge_coil_channel
    import hbridge_coil_pkg::*;
#(
    parameter int CUR_W      = 13,
    parameter int DUTY_W     = 12,
    parameter int RISE_STEP  = 4,
    parameter int FAST_STEP  = 8,
    parameter int SLOW_SHIFT = 6,
    parameter int CMP_DELAY  = 2,
    parameter int HYST       = 0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    h1,
    input  logic                    l1,
    input  logic                    h2,
    input  logic                    l2,
    input  logic                    pol_inv,
    input  logic                    pwm,
    input  logic                    wrap,
    output logic                    cmp,
    output logic signed [CUR_W-1:0] cur,
    output logic [DUTY_W-1:0]       tgt,
    output logic                    fault
);

    // Two guard bits so a step past either rail is still representable before clamping
    localparam int EW = CUR_W + 2;
    localparam logic signed [EW-1:0] CMAX = EW'(cur_max(CUR_W));
    localparam logic signed [EW-1:0] RISE = EW'(RISE_STEP);
    localparam logic signed [EW-1:0] FAST = EW'(FAST_STEP);
    localparam logic [DUTY_W:0]      TMAX = {1'b0, {DUTY_W{1'b1}}};
    localparam int MW = (CUR_W - 1 > DUTY_W) ? CUR_W - 1 : DUTY_W;

    bridge_mode_t            mode;
    logic signed [EW-1:0]    cur_ext;
    logic signed [EW-1:0]    slow_step;
    logic signed [EW-1:0]    nxt_ext;
    logic signed [CUR_W-1:0] cur_next;
    logic [DUTY_W:0]         acc;
    logic [DUTY_W:0]         acc_inc;
    logic [CUR_W-2:0]        mag;
    logic [MW-1:0]           thr;
    logic                    raw;
    logic [CMP_DELAY:0]      pipe;

    // Decode the bridge and compute the clamped next coil current
    always_comb begin
        mode      = decode_mode(h1, l1, h2, l2, pol_inv);
        cur_ext   = EW'(cur);
        slow_step = cur_ext >>> SLOW_SHIFT;
        nxt_ext   = cur_ext;
        case (mode)
            MODE_FWD: nxt_ext = cur_ext + RISE;
            MODE_REV: nxt_ext = cur_ext - RISE;
            MODE_SLOW: begin
                if (cur_ext > 0 && slow_step == 0)
                    slow_step = EW'(1);
                nxt_ext = cur_ext - slow_step;
            end
            MODE_COAST: begin
                if (cur_ext > FAST)
                    nxt_ext = cur_ext - FAST;
                else if (cur_ext < -FAST)
                    nxt_ext = cur_ext + FAST;
                else
                    nxt_ext = '0;
            end
            default: nxt_ext = cur_ext;
        endcase
        if (nxt_ext > CMAX)
            nxt_ext = CMAX;
        else if (nxt_ext < -CMAX)
            nxt_ext = -CMAX;
        cur_next = CUR_W'(nxt_ext);
    end

    // Current register; a shoot-through latches the fault and freezes the coil for good
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur   <= '0;
            fault <= 1'b0;
        end else if (!fault) begin
            if (mode == MODE_SHOOT)
                fault <= 1'b1;
            else
                cur <= cur_next;
        end
    end

    assign acc_inc = acc + (DUTY_W + 1)'(pwm);

    // Count high cycles of the reference and latch the saturated total on each wrap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
            tgt <= '0;
        end else if (wrap) begin
            acc <= '0;
            tgt <= (acc_inc > TMAX) ? DUTY_W'(TMAX) : DUTY_W'(acc_inc);
        end else begin
            acc <= acc_inc;
        end
    end

    // Magnitude against target, threshold lowered by the hysteresis while the output is high
    always_comb begin
        mag = (CUR_W - 1)'(cur[CUR_W-1] ? -cur : cur);
        thr = MW'(tgt);
        if (cmp)
            thr = (MW'(tgt) >= MW'(HYST)) ? MW'(tgt) - MW'(HYST) : '0;
        raw = MW'(mag) >= thr;
    end

    // Comparator register plus the extra delay stages, all preset high
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipe <= '1;
        end else begin
            pipe[0] <= raw;
            for (int i = 1; i <= CMP_DELAY; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign cmp = pipe[CMP_DELAY];

endmodule

// File: rtl/hbridge_coil_array.sv
// Multi-channel H-bridge coil and sense model: shared duty window plus one
// channel instance per coil.
module hbridge_coil_array
    import hbridge_coil_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int CUR_W      = 13,
    parameter int DUTY_W     = 12,
    parameter int RISE_STEP  = 4,
    parameter int FAST_STEP  = 8,
    parameter int SLOW_SHIFT = 6,
    parameter int CMP_DELAY  = 2,
    parameter int HYST       = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    hbridge_coil_array_if.slave  bus
);

    logic [DUTY_W-1:0]       win_cnt;
    logic                    wrap;
    logic [CHANNELS-1:0]     cmp_ch;
    logic [CHANNELS-1:0]     fault_ch;
    logic signed [CUR_W-1:0] cur_ch [CHANNELS];
    logic [DUTY_W-1:0]       tgt_ch [CHANNELS];

    assign wrap = &win_cnt;

    // Free-running duty window shared by every channel
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            win_cnt <= '0;
        else
            win_cnt <= win_cnt + DUTY_W'(1);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        hbridge_coil_channel #(
            .CUR_W      (CUR_W),
            .DUTY_W     (DUTY_W),
            .RISE_STEP  (RISE_STEP),
            .FAST_STEP  (FAST_STEP),
            .SLOW_SHIFT (SLOW_SHIFT),
            .CMP_DELAY  (CMP_DELAY),
            .HYST       (HYST)
        ) u_ch (
            .clk     (clk),
            .resetn  (resetn),
            .h1      (bus.high_1[i]),
            .l1      (bus.low_1[i]),
            .h2      (bus.high_2[i]),
            .l2      (bus.low_2[i]),
            .pol_inv (bus.polarity_invert[i]),
            .pwm     (bus.analog_out[i]),
            .wrap    (wrap),
            .cmp     (cmp_ch[i]),
            .cur     (cur_ch[i]),
            .tgt     (tgt_ch[i]),
            .fault   (fault_ch[i])
        );
    end

    // Pack per-channel results onto the flat bus vectors
    always_comb begin
        bus.current = '0;
        bus.target  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.current[i*CUR_W +: CUR_W]   = cur_ch[i];
            bus.target[i*DUTY_W +: DUTY_W]  = tgt_ch[i];
        end
    end

    assign bus.analog_cmp    = cmp_ch;
    assign bus.shoot_through = fault_ch;

endmodule

// File: tb/tb_hbridge_coil_array.sv
// Directed self-checking bench for hbridge_coil_array (2 channels, HYST=16, CMP_DELAY=2).
module tb_hbridge_coil_array;

    localparam int CH = 2;
    localparam int CW = 13;
    localparam int DW = 12;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_bad;

    hbridge_coil_array_if #(.CHANNELS(CH), .CUR_W(CW), .DUTY_W(DW)) bus ();

    hbridge_coil_array #(
        .CHANNELS (CH), .CUR_W (CW), .DUTY_W (DW), .RISE_STEP (4), .FAST_STEP (8),
        .SLOW_SHIFT (6), .CMP_DELAY (2), .HYST (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cur(input int ch);
        logic signed [CW-1:0] v;
        v = bus.current[ch*CW +: CW];
        return int'(v);
    endfunction

    function automatic int tgt(input int ch);
        return int'(bus.target[ch*DW +: DW]);
    endfunction

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_gates(input int ch, input logic h1, input logic l1,
                             input logic h2, input logic l2);
        bus.high_1[ch] = h1;
        bus.low_1[ch]  = l1;
        bus.high_2[ch] = h2;
        bus.low_2[ch]  = l2;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bus.high_1 = '0; bus.low_1 = '0; bus.high_2 = '0; bus.low_2 = '0;
        bus.polarity_invert = '0; bus.analog_out = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (cur(0) !== 0) begin n_bad++; $display("[TB] FAIL reset_cur0: got %0d expected 0", cur(0)); end
        n_cmp++; if (cur(1) !== 0) begin n_bad++; $display("[TB] FAIL reset_cur1: got %0d expected 0", cur(1)); end
        n_cmp++; if (bus.target !== '0) begin n_bad++; $display("[TB] FAIL reset_target: got %h expected 0", bus.target); end
        n_cmp++; if (bus.shoot_through !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_shoot: got %b expected 00", bus.shoot_through); end
        n_cmp++; if (bus.analog_cmp !== 2'b11) begin n_bad++; $display("[TB] FAIL reset_cmp: got %b expected 11", bus.analog_cmp); end
    endtask

    task automatic test_fwd_coast();
        do_reset();
        set_gates(0, 1, 0, 0, 1);
        ticks(100);
        n_cmp++; if (cur(0) !== 400) begin n_bad++; $display("[TB] FAIL fwd100_cur0: got %0d expected 400", cur(0)); end
        n_cmp++; if (cur(1) !== 0) begin n_bad++; $display("[TB] FAIL fwd100_cur1: got %0d expected 0", cur(1)); end
        ticks(412);
        n_cmp++; if (cur(0) !== 2048) begin n_bad++; $display("[TB] FAIL fwd_2048: got %0d expected 2048", cur(0)); end
        set_gates(0, 0, 0, 0, 0);
        ticks(255);
        n_cmp++; if (cur(0) !== 8) begin n_bad++; $display("[TB] FAIL coast255: got %0d expected 8", cur(0)); end
        ticks(1);
        n_cmp++; if (cur(0) !== 0) begin n_bad++; $display("[TB] FAIL coast256: got %0d expected 0", cur(0)); end
        ticks(4);
        n_cmp++; if (cur(0) !== 0) begin n_bad++; $display("[TB] FAIL coast_no_overshoot: got %0d expected 0", cur(0)); end
    endtask

    task automatic test_slow_decay();
        do_reset();
        set_gates(0, 1, 0, 0, 1);
        ticks(25);
        n_cmp++; if (cur(0) !== 100) begin n_bad++; $display("[TB] FAIL slow_start: got %0d expected 100", cur(0)); end
        set_gates(0, 0, 1, 0, 1);
        ticks(1);
        n_cmp++; if (cur(0) !== 99) begin n_bad++; $display("[TB] FAIL slow_step1: got %0d expected 99", cur(0)); end
        set_gates(0, 1, 0, 1, 0);
        ticks(98);
        n_cmp++; if (cur(0) !== 1) begin n_bad++; $display("[TB] FAIL slow_min_step: got %0d expected 1", cur(0)); end
        ticks(5);
        n_cmp++; if (cur(0) !== 0) begin n_bad++; $display("[TB] FAIL slow_zero: got %0d expected 0", cur(0)); end
    endtask

    task automatic test_duty();
        do_reset();
        bus.analog_out = 2'b11;
        ticks(1024);
        bus.analog_out[0] = 1'b0;
        ticks(3071);
        n_cmp++; if (tgt(0) !== 0) begin n_bad++; $display("[TB] FAIL duty_prewrap: got %0d expected 0", tgt(0)); end
        ticks(1);
        n_cmp++; if (tgt(0) !== 1024) begin n_bad++; $display("[TB] FAIL duty_quarter: got %0d expected 1024", tgt(0)); end
        n_cmp++; if (tgt(1) !== 4095) begin n_bad++; $display("[TB] FAIL duty_full_sat: got %0d expected 4095", tgt(1)); end
        bus.analog_out = 2'b00;
        ticks(100);
        n_cmp++; if (tgt(0) !== 1024) begin n_bad++; $display("[TB] FAIL duty_hold: got %0d expected 1024", tgt(0)); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (bus.target !== '0) begin n_bad++; $display("[TB] FAIL duty_async_reset: got %h expected 0", bus.target); end
        resetn = 1'b1;
    endtask

    task automatic test_hysteresis();
        do_reset();
        bus.analog_out[0] = 1'b1;
        ticks(1024);
        bus.analog_out[0] = 1'b0;
        ticks(3072);
        n_cmp++; if (tgt(0) !== 1024) begin n_bad++; $display("[TB] FAIL hyst_target: got %0d expected 1024", tgt(0)); end
        ticks(3);
        n_cmp++; if (bus.analog_cmp[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL hyst_initial_low: got %b expected 0", bus.analog_cmp[0]); end
        n_cmp++; if (bus.analog_cmp[1] !== 1'b1) begin n_bad++; $display("[TB] FAIL hyst_sat_zero_ch1: got %b expected 1", bus.analog_cmp[1]); end
        set_gates(0, 1, 0, 0, 1);
        ticks(256);
        n_cmp++; if (cur(0) !== 1024) begin n_bad++; $display("[TB] FAIL hyst_ramp_cur: got %0d expected 1024", cur(0)); end
        ticks(2);
        n_cmp++; if (bus.analog_cmp[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL hyst_rise_early: got %b expected 0", bus.analog_cmp[0]); end
        ticks(1);
        n_cmp++; if (bus.analog_cmp[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL hyst_rise: got %b expected 1", bus.analog_cmp[0]); end
        ticks(1);
        set_gates(0, 0, 1, 1, 0);
        ticks(11);
        n_cmp++; if (cur(0) !== 996) begin n_bad++; $display("[TB] FAIL hyst_fall_cur: got %0d expected 996", cur(0)); end
        n_cmp++; if (bus.analog_cmp[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL hyst_fall_early: got %b expected 1", bus.analog_cmp[0]); end
        ticks(1);
        n_cmp++; if (bus.analog_cmp[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL hyst_fall: got %b expected 0", bus.analog_cmp[0]); end
    endtask

    task automatic test_shoot_through();
        do_reset();
        set_gates(0, 1, 0, 0, 1);
        set_gates(1, 1, 1, 0, 1);
        ticks(1);
        n_cmp++; if (bus.shoot_through !== 2'b10) begin n_bad++; $display("[TB] FAIL shoot_set: got %b expected 10", bus.shoot_through); end
        n_cmp++; if (cur(1) !== 0) begin n_bad++; $display("[TB] FAIL shoot_hold_cur1: got %0d expected 0", cur(1)); end
        set_gates(1, 1, 0, 0, 1);
        ticks(10);
        n_cmp++; if (cur(1) !== 0) begin n_bad++; $display("[TB] FAIL shoot_frozen: got %0d expected 0", cur(1)); end
        n_cmp++; if (bus.shoot_through !== 2'b10) begin n_bad++; $display("[TB] FAIL shoot_sticky: got %b expected 10", bus.shoot_through); end
        n_cmp++; if (cur(0) !== 44) begin n_bad++; $display("[TB] FAIL shoot_ch0_free: got %0d expected 44", cur(0)); end
    endtask

    task automatic test_polarity_saturation();
        do_reset();
        bus.polarity_invert[0] = 1'b1;
        set_gates(0, 1, 0, 0, 1);
        set_gates(1, 0, 1, 1, 0);
        ticks(10);
        n_cmp++; if (cur(0) !== -40) begin n_bad++; $display("[TB] FAIL pol_invert: got %0d expected -40", cur(0)); end
        n_cmp++; if (cur(1) !== -40) begin n_bad++; $display("[TB] FAIL rev_ch1: got %0d expected -40", cur(1)); end
        bus.polarity_invert[0] = 1'b0;
        ticks(1033);
        n_cmp++; if (cur(0) !== 4092) begin n_bad++; $display("[TB] FAIL sat_approach: got %0d expected 4092", cur(0)); end
        ticks(1);
        n_cmp++; if (cur(0) !== 4095) begin n_bad++; $display("[TB] FAIL sat_pos: got %0d expected 4095", cur(0)); end
        ticks(5);
        n_cmp++; if (cur(0) !== 4095) begin n_bad++; $display("[TB] FAIL sat_pos_hold: got %0d expected 4095", cur(0)); end
        n_cmp++; if (cur(1) !== -4095) begin n_bad++; $display("[TB] FAIL sat_neg: got %0d expected -4095", cur(1)); end
        n_cmp++; if (bus.shoot_through !== 2'b00) begin n_bad++; $display("[TB] FAIL sat_no_shoot: got %b expected 00", bus.shoot_through); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_fwd_coast();
        test_slow_decay();
        test_duty();
        test_hysteresis();
        test_shoot_through();
        test_polarity_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hbridge_coil_array.md
# hbridge_coil_array

Parametrised, synthesizable multi-channel H-bridge coil and sense model for closed-loop microstepper simulation and FPGA-in-the-loop testing. Per channel it:
- decodes the four bridge gate signals into a drive/decay mode;
- integrates a saturating signed coil current;
- measures the PWM duty of the DAC reference (`analog_out`) over a fixed window;
- produces a delayed, hysteretic comparator output (`analog_cmp`) back to the microstepper.

It detects shoot-through and freezes the affected channel. It replaces per-coil models and separate duty-capture blocks in benches with N coils.

## Interface
Parameters:
- `CHANNELS`, 2, number of coils.
- `CUR_W`, 13, signed current width.
- `DUTY_W`, 12, duty window is 2^DUTY_W cycles; target width.
- `RISE_STEP`, 4, current increment per cycle while driven.
- `FAST_STEP`, 8, magnitude decrement per cycle in coast/fast decay.
- `SLOW_SHIFT`, 6, slow-decay divisor exponent.
- `CMP_DELAY`, 2, extra comparator pipeline stages (0 allowed).
- `HYST`, 0, comparator hysteresis in current LSBs.

Ports (clock and reset first):
- `clk`  in  1  sole clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `high_1`, `low_1`, `high_2`, `low_2`  in  CHANNELS each  bridge gate drives, bit i = channel i, active high.
- `polarity_invert`  in  CHANNELS  swaps forward/reverse sign per channel.
- `analog_out`  in  CHANNELS  PWM reference from the microstepper.
- `analog_cmp`  out  CHANNELS  1 when |current| ≥ target (with hysteresis).
- `current`  out  CHANNELS*CUR_W  signed coil current, channel i at [i*CUR_W +: CUR_W].
- `target`  out  CHANNELS*DUTY_W  latched duty count per channel.
- `shoot_through`  out  CHANNELS  sticky fault flag.

## Operation
- Mode decode per channel, evaluated in priority order (after polarity swap of forward/reverse):
  - `h1&l1` or `h2&l2` → SHOOT.
  - `h1&l2` → FWD.
  - `h2&l1` → REV.
  - `l1&l2` or `h1&h2` → SLOW.
  - Anything else → COAST.
- Current update, one per cycle. Current is clamped to ±(2^(CUR_W-1)−1), so −2^(CUR_W-1) never occurs.
  - FWD: current += RISE_STEP.
  - REV: current −= RISE_STEP.
  - SLOW: current −= current >>> SLOW_SHIFT, with a minimum step of 1 toward zero when current ≠ 0.
  - COAST: magnitude decreases by FAST_STEP. Clamp at 0; the sign never crosses.
  - SHOOT: set `shoot_through[i]` (sticky until reset) and hold current. While the flag is set, current holds regardless of mode.
- Duty capture:
  - A shared DUTY_W-bit window counter wraps every 2^DUTY_W cycles.
  - Each channel counts cycles with `analog_out` = 1 in a (DUTY_W+1)-bit accumulator.
  - On the wrap cycle, `target` ← min(acc including that cycle, 2^DUTY_W−1) and acc restarts at 0.
- Comparator:
  - mag = |current| (CUR_W−1 bits), zero-extended against `target` to the wider of the two widths.
  - raw = mag ≥ (cmp_q ? target−HYST saturated at 0 : target), where cmp_q is the current `analog_cmp`.
  - raw passes through CMP_DELAY registers to `analog_cmp`.

## Timing
- Reset values:
  - `current` = 0.
  - `target` = 0.
  - `shoot_through` = 0.
  - window counter and accumulators = 0.
  - `analog_cmp` and all delay stages = 1.
- `current` reflects bridge inputs sampled on the previous edge (latency 1).
- `analog_cmp` reflects `current` after 1+CMP_DELAY cycles.
- First valid `target` is visible the cycle after the 2^DUTY_W-th post-reset cycle. `target` is constant between wraps.
- Gate changes take effect on the next edge; there is no dead-time inference.
- Saturation: at +max in FWD, current holds; likewise −max in REV.
- Shoot-through takes priority over every other mode in the same cycle.
- Reset asserted mid-window or mid-pipeline clears everything immediately; no partial target is latched.

## Structure
- Package `hbridge_coil_pkg`: bridge-mode enum (FWD, REV, SLOW, COAST, SHOOT) and current-clamp constant helpers.
- Sub-module `hbridge_coil_channel`: decode, integrator, accumulator and comparator pipeline. It is instantiated CHANNELS times by a generate loop.
- Top level holds the shared window counter and wrap strobe.

## Test plan
- Reset, then hold `high_1`=`low_2`=1 on ch0 for 100 cycles → current0 = 400 at cycle 101. Ch1 stays 0.
- Drive ch0 FWD to 2048, then gates low (COAST) → current decreases by 8 per cycle to exactly 0 after 256 cycles, with no negative overshoot.
- `analog_out[0]` high 1024 of each 4096 cycles → `target0` = 1024 after the first wrap. Constant high → 4095 (saturated).
- Hold target 1024, ramp current0 through 1024 with HYST=16 and CMP_DELAY=2:
  - `analog_cmp0` rises 3 cycles after current reaches 1024;
  - then falls only once current < 1008.
- Assert `high_1`=`low_1`=1 on ch1 for 1 cycle → `shoot_through[1]` sets and stays set; current1 frozen despite later FWD; ch0 unaffected.
- `polarity_invert[0]`=1 with FWD gates for 10 cycles → current0 = −40. FWD to +max (4095) and holding 5 more cycles → current stays 4095.
